// File: rtl/sysctrl_log.sv
// System control/status register with error capture, a timed system-reset pulse
// and an error log FIFO. ERR and the log survive rst so software can read the
// error history after the system reset that the error caused.
module sysctrl_log #(
  parameter int unsigned NUM_ERR   = 8,
  parameter int unsigned LOG_DEPTH = 8,
  parameter int unsigned RST_HOLD  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stb,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [NUM_ERR-1:0] err_sig_in,
  input  logic [23:0]        err_addr_in,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               sys_rst,
  output logic               ack
);

  localparam int unsigned PW = $clog2(LOG_DEPTH);
  localparam int unsigned CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CW-1:0] HoldLoad = CW'(RST_HOLD - 1);
  localparam logic [PW:0]   FullCount = (PW + 1)'(LOG_DEPTH);

  // SCR is split so that bits 12:8 and 0 can live in flops without a reset.
  logic [18:0]   scr_hi_q;
  logic [4:0]    scr_mid_q;
  logic [6:0]    scr_lo_q;
  logic          scr_b0_q;
  logic [31:0]   scr, scr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   err_q, err_d;

  logic [31:0]   log_mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          bus_en, scr_wr, err_wr, log_rd, flush;
  logic          pulse, capture, push, pop, do_push, full, empty;
  logic [3:0]    abort_no;
  logic [31:0]   push_data;

  assign scr     = {scr_hi_q, scr_mid_q, scr_lo_q, scr_b0_q};
  assign pulse   = scr_lo_q[0];
  assign sys_rst = scr_lo_q[0];
  assign ack     = stb;

  // No register activity is accepted while rst is asserted.
  assign bus_en = stb & ~rst;
  assign scr_wr = bus_en & we & (addr == 2'd0);
  assign err_wr = bus_en & we & (addr == 2'd1);
  assign log_rd = bus_en & ~we & (addr == 2'd2);
  assign flush  = bus_en & we & (addr == 2'd3) & data_in[0];

  assign capture   = ~pulse & ~scr_wr & ~err_wr & (|err_sig_in) & ~rst;
  assign push      = err_wr | capture;
  assign push_data = err_wr ? data_in : {err_addr_in, abort_no, 4'h0};
  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign pop       = log_rd & ~empty;
  assign do_push   = push & ~flush & (~full | pop);

  // Lowest-index active error channel wins.
  always_comb begin
    abort_no = '0;
    for (int i = int'(NUM_ERR) - 1; i >= 0; i--) begin
      if (err_sig_in[i]) abort_no = 4'(i);
    end
  end

  // SCR, pulse counter and ERR next state; SCR write overrides pulse and capture.
  always_comb begin
    scr_d = scr;
    cnt_d = cnt_q;
    if (scr_wr) begin
      scr_d = data_in;
      cnt_d = HoldLoad;
    end else if (pulse) begin
      if (cnt_q == '0) scr_d[1] = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end else if (capture) begin
      scr_d[1] = 1'b1;
      cnt_d    = HoldLoad;
    end
    err_d = push ? push_data : err_q;
  end

  // Log pointer/count/overflow next state; flush beats any same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !pop)      count_d = count_q + 1'b1;
      else if (!do_push && pop) count_d = count_q - 1'b1;
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end

  // Resettable SCR bits and the hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scr_hi_q <= '0;
      scr_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      scr_hi_q <= scr_d[31:13];
      scr_lo_q <= scr_d[7:1];
      cnt_q    <= cnt_d;
    end
  end

  // State that survives rst: held SCR bits, ERR and the log.
  always_ff @(posedge clk) begin
    scr_mid_q <= scr_d[12:8];
    scr_b0_q  <= scr_d[0];
    err_q     <= err_d;
    wr_ptr_q  <= wr_ptr_d;
    rd_ptr_q  <= rd_ptr_d;
    count_q   <= count_d;
    ovf_q     <= ovf_d;
  end

  // Log storage write port.
  always_ff @(posedge clk) begin
    if (do_push) log_mem[wr_ptr_q] <= push_data;
  end

  // Combinational read mux, zero when no read is selected.
  always_comb begin
    data_out = '0;
    if (stb && !we) begin
      case (addr)
        2'd0: data_out = scr;
        2'd1: data_out = err_q;
        2'd2: data_out = empty ? 32'h0 : log_mem[rd_ptr_q];
        default: data_out = {16'h0, 8'(count_q), 5'b0, ovf_q, full, empty};
      endcase
    end
  end

endmodule

// File: tb/tb_sysctrl_log.sv
// Bench for sysctrl_log: queue-based model checked every cycle plus directed
// literal checks of the documented scenarios.
module tb_sysctrl_log;

  localparam int unsigned NUM_ERR   = 8;
  localparam int unsigned LOG_DEPTH = 8;
  localparam int unsigned RST_HOLD  = 16;

  logic               clk, rst, stb, we, sys_rst, ack;
  logic [1:0]         addr;
  logic [NUM_ERR-1:0] err_sig_in;
  logic [23:0]        err_addr_in;
  logic [31:0]        data_in, data_out;

  int checks = 0;
  int errors = 0;

  sysctrl_log #(
    .NUM_ERR  (NUM_ERR),
    .LOG_DEPTH(LOG_DEPTH),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stb        (stb),
    .we         (we),
    .addr       (addr),
    .err_sig_in (err_sig_in),
    .err_addr_in(err_addr_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .sys_rst    (sys_rst),
    .ack        (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pulse as remaining cycles, log as a queue.
  int unsigned m_rem = 0;
  logic [31:0] m_scr = '0;
  logic [31:0] m_err = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_q[$];

  function automatic logic [31:0] exp_rd();
    int sz;
    sz = m_q.size();
    if (!(stb && !we)) return 32'h0;
    case (addr)
      2'd0: return m_scr;
      2'd1: return m_err;
      2'd2: return (sz > 0) ? m_q[0] : 32'h0;
      default: return {16'h0, 8'(sz), 5'b0, m_ovf, sz == int'(LOG_DEPTH), sz == 0};
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    logic        wscr, werr, cap, push, pop, flush;
    logic [3:0]  idx;
    logic [31:0] entry;
    if (rst) begin
      m_rem = 0;
      m_scr = m_scr & 32'h0000_1F01;
    end else begin
      wscr = stb && we && addr == 2'd0;
      werr = stb && we && addr == 2'd1;
      cap  = (m_rem == 0) && !wscr && !werr && (err_sig_in != '0);
      idx  = 4'h0;
      for (int i = NUM_ERR - 1; i >= 0; i--) if (err_sig_in[i]) idx = 4'(i);
      if (wscr) begin
        m_scr = data_in;
        m_rem = data_in[1] ? RST_HOLD : 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_scr[1] = 1'b0;
      end else if (cap) begin
        m_scr[1] = 1'b1;
        m_rem    = RST_HOLD;
      end
      push  = werr || cap;
      entry = werr ? data_in : {err_addr_in, idx, 4'h0};
      if (push) m_err = entry;
      pop   = stb && !we && addr == 2'd2 && m_q.size() > 0;
      flush = stb && we && addr == 2'd3 && data_in[0];
      if (flush) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (push) begin
          if (m_q.size() < int'(LOG_DEPTH)) m_q.push_back(entry);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("sys_rst", {31'b0, sys_rst}, {31'b0, m_rem > 0});
    chk("ack", {31'b0, ack}, {31'b0, stb});
    chk("data_out", data_out, exp_rd());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    cyc();
    stb = 1'b0; we = 1'b0; data_in = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    stb = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    chk(name, data_out, exp);
    cyc();
    stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0;
    err_sig_in = '0; err_addr_in = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sys_rst", {31'b0, sys_rst}, 32'h0);
    rst = 1'b0;
    // Bring the reset-surviving state to a known point.
    wr(2'd1, 32'h0);
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h0);
    rd(2'd3, 32'h0000_0001, "init_stat");

    // 1: capture, lowest channel wins, 16-cycle pulse
    err_sig_in = 8'h24; err_addr_in = 24'h00ABCD;
    cyc();
    err_sig_in = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t1_pulse_high", {31'b0, sys_rst}, 32'h1);
    end
    @(negedge clk);
    chk("t1_pulse_end", {31'b0, sys_rst}, 32'h0);
    cyc();
    rd(2'd1, 32'h00AB_CD20, "t1_err");
    rd(2'd3, 32'h0000_0100, "t1_stat");
    rd(2'd0, 32'h0000_0000, "t1_scr");

    // 2: rst keeps SCR[12:8], SCR[0], ERR and log
    wr(2'd0, 32'h0000_1F03);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd(2'd0, 32'h0000_1F01, "t2_scr");
    rd(2'd1, 32'h00AB_CD20, "t2_err");
    rd(2'd3, 32'h0000_0100, "t2_stat");

    // 3: nine captures into an eight-deep log
    wr(2'd3, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      err_sig_in = 8'h01 << (k % 8); err_addr_in = 24'(k);
      cyc();
      err_sig_in = '0;
      wr(2'd0, 32'h0);
    end
    rd(2'd3, 32'h0000_0806, "t3_stat_full");
    for (int k = 1; k <= 8; k++) rd(2'd2, {24'(k), 4'(k % 8), 4'h0}, "t3_log_entry");
    rd(2'd2, 32'h0, "t3_empty_read");
    rd(2'd3, 32'h0000_0005, "t3_stat_empty");

    // 4: held error logged once; software trap via ERR write
    wr(2'd3, 32'h1);
    err_sig_in = 8'h80; err_addr_in = 24'h000777;
    repeat (10) cyc();
    err_sig_in = '0;
    repeat (10) cyc();
    rd(2'd3, 32'h0000_0100, "t4_logged_once");
    wr(2'd1, 32'h1234_5637);
    @(negedge clk);
    chk("t4_no_rst", {31'b0, sys_rst}, 32'h0);
    cyc();
    rd(2'd1, 32'h1234_5637, "t4_err");
    rd(2'd3, 32'h0000_0200, "t4_stat");
    rd(2'd2, 32'h0007_7770, "t4_log0");
    rd(2'd2, 32'h1234_5637, "t4_log1");

    // 5: full log, capture and pop in the same cycle
    for (int k = 1; k <= 8; k++) wr(2'd1, 32'hA000_0000 + k);
    err_sig_in = 8'h02; err_addr_in = 24'h00BEEF;
    rd(2'd2, 32'hA000_0001, "t5_pop_oldest");
    err_sig_in = '0;
    rd(2'd3, 32'h0000_0802, "t5_stat");
    for (int k = 2; k <= 8; k++) rd(2'd2, 32'hA000_0000 + k, "t5_log");
    rd(2'd2, 32'h00BE_EF10, "t5_newest");

    // 6: async rst mid-pulse, then flush clears count and overflow
    wr(2'd0, 32'h0);
    err_sig_in = 8'h01; err_addr_in = 24'h000001;
    cyc();
    err_sig_in = '0;
    repeat (4) cyc();
    chk("t6_pulse_on", {31'b0, sys_rst}, 32'h1);
    #1 rst = 1'b1;
    #1 chk("t6_async_drop", {31'b0, sys_rst}, 32'h0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) wr(2'd1, 32'h5500_0000 + k);
    rd(2'd3, 32'h0000_0806, "t6_stat_ovf");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0000_0001, "t6_stat_flushed");

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
